// File: rtl/dcache_victim_wbuf_if.sv
// Victim write-back buffer bus: dcache push/lookup side and AXI line-write side.
// The buffer is the slave; the dcache and bridge together drive the master side.
interface dcache_victim_wbuf_if #(
    parameter int DEPTH      = 4,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
);
    localparam int LW = LINE_WORDS * 32;
    localparam int CW = $clog2(DEPTH) + 1;

    logic              push_valid;
    logic              push_ready;
    logic [ADDR_W-1:0] push_addr;
    logic [LW-1:0]     push_data;
    logic [ADDR_W-1:0] lookup_addr;
    logic              lookup_hit;
    logic [LW-1:0]     lookup_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [LW-1:0]     wr_data;
    logic              wr_rdy;
    logic              wr_valid;
    logic              wbuf_empty;
    logic [CW-1:0]     wbuf_count;

    modport slave (
        input  push_valid, push_addr, push_data,
        input  lookup_addr, wr_rdy, wr_valid,
        output push_ready, lookup_hit, lookup_data,
        output wr_req, wr_addr, wr_data,
        output wbuf_empty, wbuf_count
    );

    modport master (
        output push_valid, push_addr, push_data,
        output lookup_addr, wr_rdy, wr_valid,
        input  push_ready, lookup_hit, lookup_data,
        input  wr_req, wr_addr, wr_data,
        input  wbuf_empty, wbuf_count
    );
endinterface

// File: rtl/dcache_victim_wbuf.sv
// Victim write-back buffer: circular FIFO of dirty lines with push merge,
// youngest-match refill forwarding and a one-line-at-a-time drain FSM.
module dcache_victim_wbuf #(
    parameter int DEPTH      = 4,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input logic                 clk,
    input logic                 resetn,
    dcache_victim_wbuf_if.slave bus
);
    localparam int LW    = LINE_WORDS * 32;
    localparam int OFS   = $clog2(LINE_WORDS * 4);
    localparam int TAG_W = ADDR_W - OFS;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    logic [DEPTH-1:0] vld_q;
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [LW-1:0]    data_q [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    state_t           state_q;
    logic             wr_req_q;

    logic [TAG_W-1:0] push_tag;
    logic [TAG_W-1:0] look_tag;
    logic             push_ready;
    logic             push_fire;
    logic             in_flight;
    logic             pop;
    logic             merge_hit;
    logic [PW-1:0]    merge_idx;
    logic             do_merge;
    logic             do_alloc;
    logic             look_hit;
    logic [LW-1:0]    look_data;
    logic [PW-1:0]    look_idx;
    logic             unused_ok;

    assign push_tag   = bus.push_addr[ADDR_W-1:OFS];
    assign look_tag   = bus.lookup_addr[ADDR_W-1:OFS];
    assign unused_ok  = ^{bus.push_addr[OFS-1:0],
                          bus.lookup_addr[OFS-1:0]};

    // Full check uses the registered count only, so a same-cycle
    // pop never opens a slot while full.
    assign push_ready = (count_q != CW'(DEPTH));
    assign push_fire  = bus.push_valid & push_ready;
    assign in_flight  = (state_q != S_IDLE);
    assign pop        = (state_q == S_WAIT) & bus.wr_valid;

    // Merge target search: any valid line with the push tag except
    // the in-flight head, whose data must stay frozen.
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && tag_q[i] == push_tag &&
                !(in_flight && PW'(i) == head_q)) begin
                merge_hit = 1'b1;
                merge_idx = PW'(i);
            end
        end
    end

    assign do_merge = push_fire & merge_hit;
    assign do_alloc = push_fire & ~merge_hit;

    // Refill lookup walks oldest to youngest so the youngest match
    // is the one left standing.
    always_comb begin
        look_hit  = 1'b0;
        look_data = '0;
        look_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            look_idx = head_q + PW'(i);
            if (vld_q[look_idx] && tag_q[look_idx] == look_tag) begin
                look_hit  = 1'b1;
                look_data = data_q[look_idx];
            end
        end
    end

    // Line storage: merge overwrites data in place, allocate fills
    // the tail slot. Qualified by valid bits, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_merge) begin
            data_q[merge_idx] <= bus.push_data;
        end
        if (do_alloc) begin
            tag_q[tail_q]  <= push_tag;
            data_q[tail_q] <= bus.push_data;
        end
    end

    // FIFO bookkeeping: valid bits, pointers and occupancy count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_alloc) begin
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + PW'(1);
            end
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PW'(1);
            end
            unique case (1'b1)
                do_alloc & ~pop: count_q <= count_q + CW'(1);
                pop & ~do_alloc: count_q <= count_q - CW'(1);
                default:         count_q <= count_q;
            endcase
        end
    end

    // Drain FSM: request the head line, wait for completion, pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            wr_req_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        state_q  <= S_REQ;
                        wr_req_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus.wr_rdy) begin
                        state_q  <= S_WAIT;
                        wr_req_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (bus.wr_valid) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    wr_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.push_ready  = push_ready;
    assign bus.lookup_hit  = look_hit;
    assign bus.lookup_data = look_data;
    assign bus.wr_req      = wr_req_q;
    assign bus.wr_addr     = {tag_q[head_q], {OFS{1'b0}}};
    assign bus.wr_data     = data_q[head_q];
    assign bus.wbuf_empty  = (count_q == '0) && (state_q == S_IDLE);
    assign bus.wbuf_count  = count_q;

endmodule
